// File: rtl/rhd_2048_ctrl.sv
// SPI master for 32 RHD2164 streams. All chips share CS/SCLK/MOSI. Each MISO line is
// captured by its own lane, and each lane compensates for its own cable delay.

module rhd_2048_ctrl_lane (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        fast,
    input  logic [6:0]  t,
    input  logic [7:0]  offset,
    input  logic        miso,
    output logic [15:0] word_nxt
);
    logic [15:0] sh;
    logic [7:0]  g, o, u;
    logic        cap;

    // u is the slot time seen from this lane's delayed point of view
    always_comb begin
        g        = fast ? 8'd22 : 8'd24;
        o        = (offset > g) ? g : offset;
        u        = {1'b0, t} - o;
        cap      = en && ({1'b0, t} >= o) && (u < (fast ? 8'd64 : 8'd96)) &&
                   (fast ? (u[1:0] == 2'd3) : ((u % 8'd6) == 8'd5));
        word_nxt = cap ? {sh[14:0], miso} : sh;
    end

    always_ff @(posedge clk) begin
        if (rstn) sh <= '0;
        else      sh <= word_nxt;
    end
endmodule

module rhd_2048_ctrl #(
    parameter int SEQ_ZCHECK_ITER = 64
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         config_start,
    input  logic         record_start,
    input  logic         zcheck_start,
    input  logic [6:0]   zcheck_chip_channel,
    input  logic [1:0]   zcheck_scale,
    input  logic         sampling_rate_20k,
    input  logic [255:0] oversample_offset,
    input  logic [31:0]  MISO,
    output logic         CS,
    output logic         SCLK,
    output logic         MOSI,
    output logic [7:0]   channel_out,
    output logic [511:0] rx_data,
    output logic         rx_valid,
    output logic         busy
);
    localparam int NUM_LANES = 32;
    localparam int STAGES    = 2;
    localparam int ZC_OFF    = 2 * SEQ_ZCHECK_ITER + 2;
    localparam int ZC_LAST   = ZC_OFF + 2;
    localparam int IDX_W     = ($clog2(ZC_LAST + 1) > 7) ? $clog2(ZC_LAST + 1) : 7;

    typedef enum logic [2:0] {IDLE, CONFIG, RECORD, FLUSH, ZCHECK} state_t;

    state_t                        state, state_nxt;
    logic [IDX_W-1:0]              idx, idx_nxt, zi;
    logic [6:0]                    t;
    logic [2:0]                    ph;
    logic [4:0]                    bidx;
    logic                          fast, slot_end, accept, cur_conv;
    logic [5:0]                    zch, cur_ch;
    logic [1:0]                    zscale;
    logic [15:0]                   cmd;
    logic [STAGES:1]               vld_pipe;
    logic [STAGES:1][5:0]          ch_pipe;
    logic [NUM_LANES-1:0][15:0]    word_nxt;
    logic                          unused_zch, unused_zi;

    assign unused_zch = zcheck_chip_channel[6];
    assign unused_zi  = ^zi[IDX_W-1:5];

    function automatic logic [7:0] cfg_byte(input logic [4:0] r);
        case (r)
            5'd0:  cfg_byte = 8'hDE;
            5'd1:  cfg_byte = 8'h20;
            5'd2:  cfg_byte = 8'h28;
            5'd3:  cfg_byte = 8'h02;
            5'd4:  cfg_byte = 8'h9C;
            5'd8:  cfg_byte = 8'h11;
            5'd9:  cfg_byte = 8'h80;
            5'd10: cfg_byte = 8'h10;
            5'd11: cfg_byte = 8'h80;
            5'd12: cfg_byte = 8'h10;
            5'd14, 5'd15, 5'd16, 5'd17: cfg_byte = 8'hFF;
            default: cfg_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] sine(input logic [3:0] k);
        case (k)
            4'd0:  sine = 8'd128;  4'd1:  sine = 8'd177;  4'd2:  sine = 8'd218;  4'd3:  sine = 8'd245;
            4'd4:  sine = 8'd255;  4'd5:  sine = 8'd245;  4'd6:  sine = 8'd218;  4'd7:  sine = 8'd177;
            4'd8:  sine = 8'd128;  4'd9:  sine = 8'd79;   4'd10: sine = 8'd38;   4'd11: sine = 8'd11;
            4'd12: sine = 8'd1;    4'd13: sine = 8'd11;   4'd14: sine = 8'd38;   default: sine = 8'd79;
        endcase
    endfunction

    assign busy     = (state != IDLE);
    assign slot_end = busy && (t == (fast ? 7'd85 : 7'd119));
    assign accept   = (state == IDLE) && (state_nxt != IDLE);

    // Command for the slot currently on the wire
    always_comb begin
        cmd      = 16'h0000;
        cur_conv = 1'b0;
        cur_ch   = 6'd0;
        zi       = idx - IDX_W'(2);
        case (state)
            CONFIG: begin
                if (idx < IDX_W'(18))       cmd = {2'b10, idx[5:0], cfg_byte(idx[4:0])};
                else if (idx == IDX_W'(18)) cmd = 16'h5500;
                else                        cmd = 16'hFF00;
            end
            RECORD: begin
                if (idx < IDX_W'(64)) begin
                    cmd      = {2'b00, idx[5:0], 8'h00};
                    cur_conv = 1'b1;
                    cur_ch   = idx[5:0];
                end else begin
                    cmd = 16'hE800;
                end
            end
            FLUSH: cmd = 16'hFF00;
            ZCHECK: begin
                if (idx == IDX_W'(0))      cmd = {2'b10, 6'd7, 2'b00, zch};
                else if (idx == IDX_W'(1)) cmd = {2'b10, 6'd5, 1'b0, 1'b1, 1'b0, zscale, 2'b00, 1'b1};
                else if (idx < IDX_W'(ZC_OFF)) begin
                    if (!zi[0]) begin
                        cmd = {2'b10, 6'd6, sine(zi[4:1])};
                    end else begin
                        cmd      = {2'b00, zch, 8'h00};
                        cur_conv = 1'b1;
                        cur_ch   = zch;
                    end
                end
                else if (idx == IDX_W'(ZC_OFF)) cmd = 16'h8500;
                else                            cmd = 16'hFF00;
            end
            default: cmd = 16'h0000;
        endcase
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (state == IDLE) begin
            idx_nxt = '0;
            if (config_start)      state_nxt = CONFIG;
            else if (zcheck_start) state_nxt = ZCHECK;
            else if (record_start) state_nxt = RECORD;
        end else if (slot_end) begin
            idx_nxt = idx + 1'b1;
            case (state)
                CONFIG: if (idx == IDX_W'(27)) state_nxt = IDLE;
                RECORD: if (idx == IDX_W'(64)) begin
                    idx_nxt = '0;
                    if (!record_start) state_nxt = FLUSH;
                end
                FLUSH:  if (idx == IDX_W'(1)) state_nxt = IDLE;
                ZCHECK: if (idx == IDX_W'(ZC_LAST)) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            t <= '0; ph <= '0; bidx <= 5'd16; fast <= 1'b0;
        end else if (accept || slot_end) begin
            t <= '0; ph <= '0; bidx <= '0; fast <= sampling_rate_20k;
        end else if (busy) begin
            t <= t + 7'd1;
            if (!bidx[4]) begin
                if (ph == (fast ? 3'd3 : 3'd5)) begin
                    ph   <= '0;
                    bidx <= bidx + 5'd1;
                end else begin
                    ph <= ph + 3'd1;
                end
            end
        end
    end

    assign CS   = ~(busy & ~bidx[4]);
    assign SCLK = busy & ~bidx[4] & (ph >= (fast ? 3'd2 : 3'd3));
    assign MOSI = busy & ~bidx[4] & cmd[~bidx[3:0]];

    // A result lands two slots after its command; vld_pipe[STAGES] tags the one on MISO now
    always_ff @(posedge clk) begin
        if (rstn) begin
            vld_pipe    <= '0;
            ch_pipe     <= '0;
            channel_out <= 8'hFF;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            zch         <= '0;
            zscale      <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (accept) begin
                vld_pipe <= '0;
                zch      <= zcheck_chip_channel[5:0];
                zscale   <= zcheck_scale;
            end else if (slot_end) begin
                rx_data    <= word_nxt;
                rx_valid   <= vld_pipe[2];
                vld_pipe   <= {vld_pipe[1], cur_conv};
                ch_pipe[2] <= ch_pipe[1];
                ch_pipe[1] <= cur_ch;
            end
            if (busy && t == 7'd0)
                channel_out <= vld_pipe[2] ? {2'b00, ch_pipe[2]} : 8'hFF;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        rhd_2048_ctrl_lane u_lane (
            .clk      (clk),
            .rstn     (rstn),
            .en       (busy),
            .fast     (fast),
            .t        (t),
            .offset   (oversample_offset[8*i +: 8]),
            .miso     (MISO[i]),
            .word_nxt (word_nxt[i])
        );
    end
endmodule

// File: tb/tb_rhd_2048_ctrl.sv
// Bench for rhd_2048_ctrl. It decodes MOSI, plays 32 delayed slaves and checks the
// command words, timing and received data against a model built from the command rules.

module tb_rhd_2048_ctrl;
    logic         clk = 1'b0;
    logic         rstn, config_start, record_start, zcheck_start, sampling_rate_20k;
    logic [6:0]   zcheck_chip_channel;
    logic [1:0]   zcheck_scale;
    logic [255:0] oversample_offset;
    logic [31:0]  MISO;
    logic         CS, SCLK, MOSI, rx_valid, busy;
    logic [7:0]   channel_out;
    logic [511:0] rx_data;

    always #5 clk = ~clk;

    rhd_2048_ctrl #(.SEQ_ZCHECK_ITER(64)) dut (
        .clk(clk), .rstn(rstn), .config_start(config_start), .record_start(record_start),
        .zcheck_start(zcheck_start), .zcheck_chip_channel(zcheck_chip_channel),
        .zcheck_scale(zcheck_scale), .sampling_rate_20k(sampling_rate_20k),
        .oversample_offset(oversample_offset), .MISO(MISO), .CS(CS), .SCLK(SCLK), .MOSI(MOSI),
        .channel_out(channel_out), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
    );

    localparam logic [7:0] CFG [0:17] = '{8'hDE, 8'h20, 8'h28, 8'h02, 8'h9C, 8'h00, 8'h00, 8'h00, 8'h11,
                                          8'h80, 8'h10, 8'h80, 8'h10, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    localparam logic [7:0] SINE [0:15] = '{8'd128, 8'd177, 8'd218, 8'd245, 8'd255, 8'd245, 8'd218, 8'd177,
                                           8'd128, 8'd79, 8'd38, 8'd11, 8'd1, 8'd11, 8'd38, 8'd79};

    int          n_chk = 0, n_pass = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  ch_q[$];
    bit          mon_en = 1'b0;
    logic [15:0] slv_word = 16'h0000;
    int          dly [32];
    int          pb = 6, gb = 24, exp_t = 120;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] req);
        n_chk++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    endtask

    // ---------------- model: command words straight from the encodings ----------------
    task automatic push_cfg();
        for (int r = 0; r < 18; r++) exp_q.push_back({2'b10, 6'(r), CFG[r]});
        exp_q.push_back(16'h5500);
        for (int i = 0; i < 9; i++) exp_q.push_back(16'hFF00);
    endtask

    task automatic push_rec(input int frames);
        for (int f = 0; f < frames; f++) begin
            for (int c = 0; c < 64; c++) begin
                exp_q.push_back(16'(c << 8));
                ch_q.push_back(8'(c));
            end
            exp_q.push_back(16'hE800);
        end
        exp_q.push_back(16'hFF00);
        exp_q.push_back(16'hFF00);
    endtask

    task automatic push_zc(input logic [5:0] ch, input logic [1:0] sc);
        exp_q.push_back(16'h8700 | 16'(ch));
        exp_q.push_back(16'h8540 | (16'(sc) << 3) | 16'h0001);
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(16'h8600 | 16'(SINE[k % 16]));
            exp_q.push_back(16'(ch) << 8);
            ch_q.push_back({2'b00, ch});
        end
        exp_q.push_back(16'h8500);
        exp_q.push_back(16'hFF00);
        exp_q.push_back(16'hFF00);
    endtask

    task automatic set_mode(input bit fast, input bit directed);
        int off;
        sampling_rate_20k = fast;
        pb    = fast ? 4 : 6;
        gb    = fast ? 22 : 24;
        exp_t = 16 * pb + gb;
        for (int s = 0; s < 32; s++) begin
            if (directed) off = (s == 31) ? 255 : ((s % 3 == 0) ? 0 : (s % 3 == 1) ? 5 : 22);
            else          off = $urandom_range(0, 40);
            oversample_offset[8*s +: 8] = 8'(off);
            dly[s] = (off > gb) ? gb : off;
        end
    endtask

    // ---------------- monitor and delayed slaves ----------------
    logic    prev_cs = 1'b1, prev_sclk = 1'b0;
    int      cyc = 0, nrise = 0;
    longint  cycn = 0, last_fall = -1;
    logic [15:0] sh = '0;
    bit      hist [0:31];
    bit      id;

    always @(posedge clk) begin
        #1;
        cycn++;
        if (!CS && prev_cs) begin
            if (mon_en && last_fall >= 0) chk("slot_period", 512'(cycn - last_fall), 512'(exp_t));
            last_fall = cycn;
            cyc = 0;
            nrise = 0;
        end else begin
            cyc++;
        end
        if (!busy) last_fall = -1;
        if (SCLK && !prev_sclk) begin
            chk("sclk_only_busy", 512'(busy), 512'(1));
            sh = {sh[14:0], MOSI};
            nrise++;
        end
        if (CS && !prev_cs && mon_en) begin
            chk("sclk_rises", 512'(nrise), 512'(16));
            chk("slot_expected", 512'(exp_q.size() > 0), 512'(1));
            if (exp_q.size() > 0) chk("mosi_word", 512'(sh), 512'(exp_q.pop_front()));
        end
        if (rx_valid && mon_en) begin
            chk("valid_expected", 512'(ch_q.size() > 0), 512'(1));
            if (ch_q.size() > 0) chk("channel_out", 512'(channel_out), 512'(ch_q.pop_front()));
            chk("rx_data", rx_data, {32{slv_word}});
        end
        id = (!CS && cyc < 16 * pb) ? slv_word[4'(15 - cyc / pb)] : 1'b0;
        for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = id;
        for (int s = 0; s < 32; s++) MISO[s] = hist[dly[s]];
        prev_cs = CS;
        prev_sclk = SCLK;
    end

    // kind 0: config (with a simultaneous zcheck start), 1: record, 2: zcheck
    task automatic run_seq(input int kind, input int slots, input int hold);
        longint t0;
        int n;
        @(posedge clk); #1;
        case (kind)
            0: begin config_start = 1'b1; zcheck_start = 1'b1; end
            1: record_start = 1'b1;
            default: zcheck_start = 1'b1;
        endcase
        @(posedge clk); #1;
        config_start = 1'b0;
        zcheck_start = 1'b0;
        chk("busy_rise", 512'(busy), 512'(1));
        t0 = $time;
        repeat (hold) @(posedge clk);
        #1;
        config_start = 1'b1;
        zcheck_start = 1'b1;
        @(posedge clk); #1;
        config_start = 1'b0;
        zcheck_start = 1'b0;
        record_start = 1'b0;
        n = 0;
        while (busy && n < 30000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("seq_done", 512'(busy), 512'(0));
        chk("seq_cycles", 512'(($time - t0) / 10), 512'(slots * exp_t));
        repeat (3) @(posedge clk);
        #1;
        chk("words_consumed", 512'(exp_q.size()), 512'(0));
        chk("valids_consumed", 512'(ch_q.size()), 512'(0));
    endtask

    initial begin
        rstn = 1'b1; config_start = 1'b0; record_start = 1'b0; zcheck_start = 1'b0;
        zcheck_chip_channel = 7'd0; zcheck_scale = 2'd0; MISO = '0;
        oversample_offset = '0;
        set_mode(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", 512'(CS), 512'(1));
        chk("rst_sclk", 512'(SCLK), 512'(0));
        chk("rst_mosi", 512'(MOSI), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_chan", 512'(channel_out), 512'(8'hFF));
        chk("rst_valid", 512'(rx_valid), 512'(0));
        chk("rst_rx", rx_data, 512'(0));
        rstn = 1'b0;
        repeat (20) @(posedge clk);
        mon_en = 1'b1;

        slv_word = 16'($urandom);
        push_cfg();
        run_seq(0, 28, 500);

        slv_word = 16'($urandom);
        set_mode(1'b0, 1'b0);
        push_rec(1);
        run_seq(1, 67, 1200);

        slv_word = 16'($urandom);
        set_mode(1'b1, 1'b0);
        push_rec(1);
        run_seq(1, 67, 900);

        slv_word = 16'($urandom);
        set_mode(1'b0, 1'b0);
        zcheck_chip_channel = 7'h7D;
        zcheck_scale = 2'd3;
        push_zc(6'd61, 2'd3);
        run_seq(2, 133, 700);

        slv_word = 16'hA5C3;
        set_mode(1'b0, 1'b1);
        push_cfg();
        run_seq(0, 28, 300);
        chk("offset_rx", rx_data, {32{16'hA5C3}});

        slv_word = 16'($urandom);
        zcheck_chip_channel = 7'($urandom_range(0, 127));
        zcheck_scale = 2'($urandom_range(0, 3));
        push_zc(zcheck_chip_channel[5:0], zcheck_scale);
        @(posedge clk); #1;
        zcheck_start = 1'b1;
        @(posedge clk); #1;
        zcheck_start = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("abort_cs", 512'(CS), 512'(1));
        chk("abort_sclk", 512'(SCLK), 512'(0));
        chk("abort_busy", 512'(busy), 512'(0));
        chk("abort_chan", 512'(channel_out), 512'(8'hFF));
        chk("abort_rx", rx_data, 512'(0));
        rstn = 1'b0;
        exp_q.delete();
        ch_q.delete();
        repeat (5) @(posedge clk);
        #1;
        mon_en = 1'b1;

        slv_word = 16'($urandom);
        set_mode(1'b1, 1'b0);
        push_cfg();
        run_seq(0, 28, 400);
        chk("cfg20k_rx", rx_data, {32{slv_word}});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rhd_2048_ctrl.md
Name: rhd_2048_ctrl

Overview:
- SPI master for 32 RHD2164 data streams: 16 headstage ports A..P, each with MISO1/MISO2, giving 2048 channels.
- All chips share one CS/SCLK/MOSI; each stream has its own MISO line and its own per-stream capture-delay (cable-delay) compensation.
- Runs three sequences: register configuration, continuous recording, impedance check. Publishes the received words on a wide bus.

Parameters:
- SEQ_ZCHECK_ITER, 64, number of DAC-write/CONVERT pairs in the impedance check.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous reset, active-high (asserted = 1, despite the codebase name).
- config_start  in  1  pulse; starts the configuration sequence.
- record_start  in  1  level; records while high.
- zcheck_start  in  1  pulse; starts the impedance check.
- zcheck_chip_channel  in  7  channel under test; bits [5:0] are used.
- zcheck_scale  in  2  zcheck capacitor scale.
- sampling_rate_20k  in  1  selects fast SPI timing.
- oversample_offset  in  256  8-bit capture delay per stream, in clk cycles; byte s = stream s, order A1,A2,B1,…,P2.
- MISO  in  32  bit s = stream s, same order as oversample_offset.
- CS  out  1  chip select, active low.
- SCLK  out  1  SPI clock, idle low.
- MOSI  out  1  command data, MSB first.
- channel_out  out  8  channel whose result is currently on MISO; 8'hFF when the result is not from a CONVERT.
- rx_data  out  512  captured 16-bit words; word s = bits [16s+15:16s].
- rx_valid  out  1  one-clk pulse when rx_data holds CONVERT results.
- busy  out  1  high while any sequence is running.

Behaviour:
- Reset values: CS=1, SCLK=0, MOSI=0, channel_out=8'hFF, rx_data=0, rx_valid=0, busy=0, FSM=IDLE.
- Command slot timing:
  - P=6 clocks per bit and G=24 gap clocks; when sampling_rate_20k=1, P=4 and G=22.
  - Slot length T=16P+G (120 or 86 clocks). Slot counter t runs 0..T-1.
  - CS=0 for t<16P, CS=1 otherwise.
  - Bit b occupies t in [bP,(b+1)P): SCLK=0 for the first P/2 clocks, then 1. MOSI=cmd[15-b].
  - sampling_rate_20k is sampled only at slot start.
- Capture:
  - Stream s uses o=min(offset_s,G).
  - It shifts MISO[s] into a 16-bit register (MSB first) at t=bP+P-1+o, for b=0..15.
  - At t=T-1 all 32 registers load into rx_data. rx_valid pulses the next clock if that slot's result came from a CONVERT.
- Pipeline:
  - The result of a command appears two slots later.
  - channel_out is updated at slot start to the channel of the CONVERT issued two slots earlier, else 8'hFF.
- Command encodings:
  - CONVERT(c) = {2'b00,c[5:0],8'h00}
  - WRITE(r,d) = {2'b10,r[5:0],d}
  - READ(r) = {2'b11,r[5:0],8'h00}
  - CALIBRATE = 16'h5500
- FSM states: IDLE, CONFIG, RECORD, FLUSH, ZCHECK.
  - Starts are accepted only in IDLE; starts while busy are ignored.
  - Simultaneous starts: priority config > zcheck > record.
- CONFIG: 28 slots.
  - WRITE to regs 0..17 with data DE,20,28,02,9C,00,00,00,11,80,10,80,10,00,FF,FF,FF,FF (hex).
  - Then CALIBRATE, then 9× READ(63).
  - Then IDLE.
- RECORD: frames of 65 slots, CONVERT(0..63) then READ(40).
  - Frames repeat back-to-back while record_start=1.
  - When record_start is low at a frame end, go to FLUSH.
- FLUSH: 2× READ(63), so the last two results are delivered. Then IDLE.
- ZCHECK:
  - WRITE(7,{2'b0,ch[5:0]}).
  - WRITE(5,{1'b0,1'b1,1'b0,scale,2'b00,1'b1}).
  - Then SEQ_ZCHECK_ITER pairs: WRITE(6,sine[k mod 16]) followed by CONVERT(ch).
  - Then WRITE(5,8'h00), 2× READ(63), IDLE.
  - sine LUT = 128,177,218,245,255,245,218,177,128,79,38,11,1,11,38,79.
- Reset mid-sequence aborts immediately to the reset values.
- busy=1 from the first clock after an accepted start until the clock of the return to IDLE.

Test Plan:
- Reset: hold rstn=1 for 3 clocks → CS=1, SCLK=0, busy=0, channel_out=FF; no SCLK edges while idle.
- Config: pulse config_start → 28 CS-low windows; words 0x80DE, 0x8120, …, 0x91FF, 0x5500, then 9×0xFF00; each slot is 120 clocks; busy falls after slot 28.
- Record: hold record_start high for 1 frame, then drop →
  - 65+2 slots; slot k word = k<<8 for k<64; slot 64 = 0xE800; the 2 flush slots = 0xFF00.
  - 64 rx_valid pulses; channel_out = 0..63 in order.
- 20k mode: set sampling_rate_20k=1 and repeat record → slot period 86 clocks, 16 SCLK rising edges per CS-low window.
- Zcheck with ch=61, scale=3 → first words 0x873D, 0x8559, 0x8680, 0x3D00, 0x86B1, 0x3D00; rx_valid accompanies channel_out=61.
- Offset: a slave drives known word 0xA5C3 delayed by d ∈ {0,5,22} clocks, with oversample_offset=d → rx_data word equals 0xA5C3 for all 32 streams.
